// File: rtl/pll_seq_pkg.sv
// Shared types and sizing helpers for the PLL reset sequencer.
// Imported by the interface, the top level and the bench-facing modport users.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        RST_PLL   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } seq_state_e;

    localparam int unsigned LOSS_CNT_W = 8;

    // The shared phase counter only ever reaches (longest phase - 1).
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// Control/status bundle between the PLL reset sequencer and the board side
// (PLL reset/lock pins, downstream reset, status counters).
interface pll_reset_sequencer_if #(
    parameter int unsigned MAX_RETRIES = 3
) ();
    import pll_seq_pkg::*;

    localparam int unsigned RETRY_W = $clog2(MAX_RETRIES + 1);

    logic                  pll_lock;
    logic                  reinit;
    logic                  pll_rst;
    logic                  sys_rst;
    logic                  ready;
    logic                  error;
    logic [RETRY_W-1:0]    retry_cnt;
    logic [LOSS_CNT_W-1:0] loss_cnt;

    modport master (
        input  pll_lock,
        input  reinit,
        output pll_rst,
        output sys_rst,
        output ready,
        output error,
        output retry_cnt,
        output loss_cnt
    );

    modport slave (
        output pll_lock,
        output reinit,
        input  pll_rst,
        input  sys_rst,
        input  ready,
        input  error,
        input  retry_cnt,
        input  loss_cnt
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; both stages reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Power-up/recovery sequencer for the DDR3 rPLL: pulses PLL reset, waits for a
// debounced LOCK with bounded retries, then releases the system reset.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned RST_CYCLES    = 64,
    parameter int unsigned LOCK_TIMEOUT  = 27000,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRIES   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    pll_reset_sequencer_if.master bus
);

    localparam int unsigned CNT_W   = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int unsigned RETRY_W = $clog2(MAX_RETRIES + 1);

    seq_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [RETRY_W-1:0]    retry_q, retry_d;
    logic [LOSS_CNT_W-1:0] loss_q, loss_d;
    logic                  pll_rst_q, pll_rst_d;
    logic                  sys_rst_q, sys_rst_d;
    logic                  ready_q, ready_d;
    logic                  error_q, error_d;
    logic                  lock_s;

    sync_2ff u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.pll_lock),
        .q   (lock_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RST_PLL;
            cnt_q     <= '0;
            retry_q   <= '0;
            loss_q    <= '0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            loss_q    <= loss_d;
            pll_rst_q <= pll_rst_d;
            sys_rst_q <= sys_rst_d;
            ready_q   <= ready_d;
            error_q   <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        loss_d  = loss_q;

        if (bus.reinit) begin
            state_d = RST_PLL;
            retry_d = '0;
        end else begin
            case (state_q)
                RST_PLL: begin
                    if (cnt_q == CNT_W'(RST_CYCLES - 1)) state_d = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = STABLE;
                    end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                        if (retry_q == RETRY_W'(MAX_RETRIES)) begin
                            state_d = FAIL;
                        end else begin
                            retry_d = retry_q + 1'b1;
                            state_d = RST_PLL;
                        end
                    end
                end
                STABLE: begin
                    // A drop here is a debounce failure, not a timeout: retries untouched.
                    if (!lock_s) begin
                        state_d = WAIT_LOCK;
                    end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
                        state_d = RUN;
                        retry_d = '0;
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state_d = RST_PLL;
                        if (loss_q != '1) loss_d = loss_q + 1'b1;
                    end
                end
                FAIL: begin
                    state_d = FAIL;
                end
                default: begin
                    state_d = RST_PLL;
                end
            endcase
        end

        // Counter only runs in timed phases; it restarts on any phase entry or reinit.
        if (bus.reinit || (state_d != state_q) || (state_d inside {RUN, FAIL})) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        // Outputs are decoded from the next state so they register alongside it.
        pll_rst_d = (state_d == RST_PLL);
        sys_rst_d = (state_d != RUN);
        ready_d   = (state_d == RUN);
        error_d   = (state_d == FAIL);
    end

    assign bus.pll_rst   = pll_rst_q;
    assign bus.sys_rst   = sys_rst_q;
    assign bus.ready     = ready_q;
    assign bus.error     = error_q;
    assign bus.retry_cnt = retry_q;
    assign bus.loss_cnt  = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Randomized self-checking bench for pll_reset_sequencer against a phase/age
// reference model with a two-sample lock delay line.
module tb_pll_reset_sequencer;

    localparam int RST_C = 4;
    localparam int TO    = 20;
    localparam int ST    = 8;
    localparam int MR    = 2;

    localparam int P_HOLD   = 0;
    localparam int P_ACQ    = 1;
    localparam int P_SETTLE = 2;
    localparam int P_ON     = 3;
    localparam int P_DEAD   = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pll_reset_sequencer_if #(.MAX_RETRIES(MR)) bus ();

    pll_reset_sequencer #(
        .RST_CYCLES    (RST_C),
        .LOCK_TIMEOUT  (TO),
        .STABLE_CYCLES (ST),
        .MAX_RETRIES   (MR)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int m_phase;
    int m_age;
    int m_retries;
    int m_losses;
    bit lock_hist[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase   = P_HOLD;
        m_age     = 0;
        m_retries = 0;
        m_losses  = 0;
        lock_hist.delete();
        lock_hist.push_back(1'b0);
        lock_hist.push_back(1'b0);
    endtask

    // One clock edge of the reference: lock seen by the sequencer is two samples old.
    task automatic model_edge(input bit lock_in, input bit reinit_in);
        bit ls;
        int nxt;
        int spent;
        ls = lock_hist.pop_front();
        lock_hist.push_back(lock_in);
        spent = m_age + 1;
        nxt   = m_phase;
        if (reinit_in) begin
            nxt = P_HOLD;
            m_retries = 0;
        end else if (m_phase == P_HOLD) begin
            if (spent == RST_C) nxt = P_ACQ;
        end else if (m_phase == P_ACQ) begin
            if (ls) begin
                nxt = P_SETTLE;
            end else if (spent == TO) begin
                if (m_retries == MR) begin
                    nxt = P_DEAD;
                end else begin
                    m_retries++;
                    nxt = P_HOLD;
                end
            end
        end else if (m_phase == P_SETTLE) begin
            if (!ls) begin
                nxt = P_ACQ;
            end else if (spent == ST) begin
                nxt = P_ON;
                m_retries = 0;
            end
        end else if (m_phase == P_ON) begin
            if (!ls) begin
                nxt = P_HOLD;
                if (m_losses < 255) m_losses++;
            end
        end
        m_age   = (reinit_in || nxt != m_phase) ? 0 : spent;
        m_phase = nxt;
    endtask

    function automatic logic [31:0] model_vec();
        logic [31:0] v;
        v       = '0;
        v[13]   = (m_phase == P_HOLD);
        v[12]   = (m_phase != P_ON);
        v[11]   = (m_phase == P_ON);
        v[10]   = (m_phase == P_DEAD);
        v[9:8]  = 2'(m_retries);
        v[7:0]  = 8'(m_losses);
        return v;
    endfunction

    function automatic logic [31:0] dut_vec();
        logic [31:0] v;
        v       = '0;
        v[13]   = bus.pll_rst;
        v[12]   = bus.sys_rst;
        v[11]   = bus.ready;
        v[10]   = bus.error;
        v[9:8]  = bus.retry_cnt;
        v[7:0]  = bus.loss_cnt;
        return v;
    endfunction

    task automatic tick(input bit lock_v, input bit reinit_v);
        bus.pll_lock = lock_v;
        bus.reinit   = reinit_v;
        @(posedge clk);
        model_edge(lock_v, reinit_v);
        #1;
        check_eq("cycle", dut_vec(), model_vec());
    endtask

    task automatic apply_reset();
        rst        = 1'b1;
        bus.reinit = 1'b0;
        #1;
        model_reset();
        check_eq("rst_assert", dut_vec(), model_vec());
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_ready(input int budget);
        int n;
        n = 0;
        while (!bus.ready && n < budget) begin
            tick(1'b1, 1'b0);
            n++;
        end
        check_eq("wait_ready", 32'(bus.ready), 32'd1);
    endtask

    task automatic wait_error(input int budget);
        int n;
        n = 0;
        while (!bus.error && n < budget) begin
            tick(1'b0, 1'b0);
            n++;
        end
        check_eq("wait_error", 32'(bus.error), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        bus.pll_lock = 1'b1;
        bus.reinit   = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_vals", dut_vec(), model_vec());
        check_eq("reset_pll_rst", 32'(bus.pll_rst), 32'd1);
        rst = 1'b0;

        // Clean bring-up with lock held high
        for (int i = 1; i <= 13; i++) begin
            tick(1'b1, 1'b0);
            if (i == 3)  check_eq("s1_pll_rst_held", 32'(bus.pll_rst), 32'd1);
            if (i == 4)  check_eq("s1_pll_rst_rel", 32'(bus.pll_rst), 32'd0);
            if (i == 12) check_eq("s1_ready_early", 32'(bus.ready), 32'd0);
            if (i == 13) begin
                check_eq("s1_ready", 32'(bus.ready), 32'd1);
                check_eq("s1_sys_rst", 32'(bus.sys_rst), 32'd0);
                check_eq("s1_retry", 32'(bus.retry_cnt), 32'd0);
            end
        end

        // One-cycle lock drop in RUN
        repeat ($urandom_range(1, 20)) tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        check_eq("s3_ready_d0", 32'(bus.ready), 32'd1);
        tick(1'b1, 1'b0);
        check_eq("s3_ready_d1", 32'(bus.ready), 32'd1);
        tick(1'b1, 1'b0);
        check_eq("s3_ready_d2", 32'(bus.ready), 32'd0);
        check_eq("s3_sys_rst", 32'(bus.sys_rst), 32'd1);
        check_eq("s3_loss", 32'(bus.loss_cnt), 32'd1);
        wait_ready(60);

        // Glitch during the debounce window restarts it
        tick(1'b1, 1'b1);
        for (int i = 1; i <= 20; i++) begin
            tick((i == 9) ? 1'b0 : 1'b1, 1'b0);
            if (i == 11) check_eq("s4_retry", 32'(bus.retry_cnt), 32'd0);
            if (i == 19) check_eq("s4_ready_early", 32'(bus.ready), 32'd0);
            if (i == 20) check_eq("s4_ready", 32'(bus.ready), 32'd1);
        end

        // Permanent lock loss drives the sequencer into its failure state
        wait_error(200);
        check_eq("fail_pll_rst", 32'(bus.pll_rst), 32'd0);
        check_eq("fail_sys_rst", 32'(bus.sys_rst), 32'd1);

        // reinit out of failure, loss count kept
        tick(1'b1, 1'b1);
        check_eq("s5_error_clr", 32'(bus.error), 32'd0);
        check_eq("s5_pll_rst", 32'(bus.pll_rst), 32'd1);
        for (int i = 1; i <= 13; i++) begin
            tick(1'b1, 1'b0);
            if (i == 3)  check_eq("s5_pll_rst_held", 32'(bus.pll_rst), 32'd1);
            if (i == 4)  check_eq("s5_pll_rst_rel", 32'(bus.pll_rst), 32'd0);
            if (i == 13) check_eq("s5_ready", 32'(bus.ready), 32'd1);
        end
        check_eq("s5_loss_kept", 32'(bus.loss_cnt), 32'd2);

        // reinit and lock loss seen in the same RUN cycle
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        check_eq("reinit_vs_loss", 32'(bus.loss_cnt), 32'd2);
        check_eq("reinit_vs_loss_rst", 32'(bus.pll_rst), 32'd1);
        wait_ready(60);

        // Timeout retries from reset with no lock
        apply_reset();
        for (int i = 1; i <= 172; i++) begin
            tick(1'b0, 1'b0);
            if (i == 24) check_eq("s2_retry1", 32'(bus.retry_cnt), 32'd1);
            if (i == 48) check_eq("s2_retry2", 32'(bus.retry_cnt), 32'd2);
            if (i == 71) check_eq("s2_error_early", 32'(bus.error), 32'd0);
            if (i == 72) begin
                check_eq("s2_error", 32'(bus.error), 32'd1);
                check_eq("s2_pll_rst", 32'(bus.pll_rst), 32'd0);
                check_eq("s2_sys_rst", 32'(bus.sys_rst), 32'd1);
            end
            if (i == 172) check_eq("s2_error_hold", 32'(bus.error), 32'd1);
        end

        // Random lock segments with occasional reinit
        for (int seg = 0; seg < 120; seg++) begin
            bit lv;
            int len;
            lv  = bit'($urandom_range(0, 1));
            len = int'($urandom_range(1, 30));
            for (int j = 0; j < len; j++) begin
                tick(lv, ($urandom_range(0, 63) == 0));
            end
        end

        // Loss counter saturation
        tick(1'b1, 1'b1);
        wait_ready(60);
        for (int k = 0; k < 300; k++) begin
            tick(1'b0, 1'b0);
            tick(1'b1, 1'b0);
            tick(1'b1, 1'b0);
            wait_ready(60);
        end
        check_eq("s6_loss_sat", 32'(bus.loss_cnt), 32'd255);

        // Asynchronous reset in the middle of lock acquisition
        tick(1'b0, 1'b1);
        repeat (5) tick(1'b0, 1'b0);
        check_eq("s6_in_wait", 32'(bus.pll_rst), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_eq("s6_async_vals", dut_vec(), model_vec());
        check_eq("s6_async_pll_rst", 32'(bus.pll_rst), 32'd1);
        check_eq("s6_async_loss", 32'(bus.loss_cnt), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_ready(60);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Power-up and recovery controller for the board rPLL that generates the DDR3 clocks from the 27 MHz reference.
- Holds the PLL in reset, waits for LOCK with a timeout, and debounces LOCK.
- Releases the downstream system/DDR3 reset only after LOCK has been stable.
- Re-sequences on lock loss, on request, or on timeout with bounded retries. Runs in the reference-clock domain, never on a PLL output.

Parameters:
- RST_CYCLES, 64: cycles pll_rst is held high per PLL reset attempt.
- LOCK_TIMEOUT, 27000: cycles to wait for synchronized lock (1 ms at 27 MHz) before retry.
- STABLE_CYCLES, 1024: consecutive cycles lock must stay high before sys_rst release.
- MAX_RETRIES, 3: timeout retries allowed before entering FAIL.

Ports:
- clk  in  1  27 MHz reference clock, same net driving PLL clkin.
- rst  in  1  asynchronous, active-high reset.
- pll_lock  in  1  raw PLL LOCK, asynchronous to clk.
- reinit  in  1  single-cycle request to restart full sequence.
- pll_rst  out  1  drives PLL RESET, active-high.
- sys_rst  out  1  downstream/DDR3 reset, active-high.
- ready  out  1  high only in RUN.
- error  out  1  high only in FAIL (sticky).
- retry_cnt  out  2  timeout retries used in current attempt ($clog2(MAX_RETRIES+1)).
- loss_cnt  out  8  saturating count of lock losses observed in RUN.

Interface:
- One clock; reset is asynchronous and active-high: clk, rst.

Behaviour:
- Reset values: state=RST_PLL, pll_rst=1, sys_rst=1, ready=0, error=0, retry_cnt=0, loss_cnt=0, cnt=0.
- All outputs are registered.
- pll_lock passes through a 2-FF synchronizer to give lock_s, adding 2 cycles of latency. Synchronizer flops reset to 0.
- Single counter cnt, sized for the maximum of all parameters. cnt clears on every state change.
- RST_PLL:
  - pll_rst=1, sys_rst=1.
  - After exactly RST_CYCLES cycles in the state, go to WAIT_LOCK, with pll_rst=0 from the first WAIT_LOCK cycle.
- WAIT_LOCK:
  - If lock_s=1, go to STABLE.
  - Else, when cnt reaches LOCK_TIMEOUT-1: if retry_cnt==MAX_RETRIES go to FAIL; otherwise retry_cnt++ and go to RST_PLL.
- STABLE:
  - If lock_s=0, go to WAIT_LOCK. This is not a timeout, so retry_cnt is unchanged.
  - After STABLE_CYCLES consecutive cycles of lock_s=1, go to RUN and clear retry_cnt.
- RUN:
  - sys_rst=0, ready=1.
  - If lock_s=0: the next cycle has sys_rst=1, ready=0, state=RST_PLL, and loss_cnt increments, saturating at 255.
- FAIL:
  - pll_rst=0, sys_rst=1, error=1.
  - Exits only on reinit or rst.
- reinit (any state, including FAIL):
  - Next state is RST_PLL, with sys_rst=1, ready=0, error=0, retry_cnt=0 and cnt cleared.
  - loss_cnt is unchanged.
- Priority: rst > reinit > lock-loss/timeout > normal progression.
- If reinit and lock loss occur in the same RUN cycle, reinit wins and loss_cnt does not increment.
- sys_rst is never deasserted outside RUN.
- pll_rst is deasserted in every state except RST_PLL.
- rst asserted mid-sequence immediately forces reset values, including pll_rst=1.

Decomposition:
- Package pll_seq_pkg holds:
  - the state enum (RST_PLL, WAIT_LOCK, STABLE, RUN, FAIL);
  - a width-helper function for the counter width;
  - a LOSS_CNT_W=8 constant.
- Sub-module sync_2ff (1-bit, async active-high reset, reset value 0) for pll_lock.

Test Plan:
All scenarios use RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2.
1. rst release with pll_lock=1 constant -> pll_rst high for 4 cycles; WAIT_LOCK sees lock_s 2 cycles later; sys_rst falls and ready rises 8 cycles after entering STABLE; retry_cnt=0.
2. pll_lock=0 constant -> three RST_PLL/WAIT_LOCK rounds with retry_cnt 0,1,2; the third timeout enters FAIL with error=1, sys_rst=1, pll_rst=0; state holds for 100 further cycles.
3. In RUN, drop pll_lock for 1 cycle -> sys_rst=1 and ready=0 3 cycles after the drop; loss_cnt=1; full resequence to RUN afterwards.
4. In STABLE, glitch pll_lock low at STABLE cycle 5 -> return to WAIT_LOCK, retry_cnt unchanged, STABLE count restarts; RUN not reached before 8 clean cycles.
5. In FAIL, pulse reinit with pll_lock=1 -> error=0, pll_rst=1 for 4 cycles, then reach RUN; loss_cnt preserved.
6. Assert rst asynchronously mid-WAIT_LOCK, and separately force 300 lock losses -> rst gives immediate reset values with pll_rst=1; loss_cnt saturates at 255.
